roberto_resposta_uc: RTL
========================

Name: roberto_resposta_uc

Overview:
- Peer-side control unit for the sensor link. Receives the serial frame of N_SENSORES ASCII distance fields, each N_DIGITOS digits plus a terminator, from a UART receiver.
- Decodes each field to binary and publishes all distances atomically.
- Then transmits N_RESPOSTA reply bytes (servo commands) back through a UART transmitter.
- Sits between uart rx/tx and the servo/decision logic on the receiving end of the link.

Parameters:
N_SENSORES, 3, sensor fields per frame
N_DIGITOS, 3, ASCII decimal digits per field
LARGURA, 10, bits per decoded distance (holds 999)
TERMINADOR, 8'h23, field terminator byte ('#')
N_RESPOSTA, 3, reply bytes per frame
TIMEOUT, 50_000_000, idle clock cycles allowed between bytes of a partial frame

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low (reset = 0 resets)
habilita  in  1  enables frame reception
rx_dado  in  8  received byte
rx_pronto  in  1  one-cycle pulse; rx_dado valid this cycle
tx_pronto  in  1  one-cycle pulse; transmitter finished current byte
resposta  in  8*N_RESPOSTA  reply bytes, sampled at frame completion
tx_partida  out  1  one-cycle start pulse to transmitter
tx_dado  out  8  byte to transmit
distancias  out  LARGURA*N_SENSORES  decoded distances; sensor 0 in the LSBs
distancias_validas  out  1  one-cycle pulse when distancias updates
erro  out  1  one-cycle pulse on framing error or timeout
pronto  out  1  one-cycle pulse when reply is fully sent
db_estado  out  4  current state code

Behaviour:
- Reset (reset = 0, asynchronous):
  - All outputs 0.
  - Internal accumulator, digit/sensor/reply counters, timeout counter and latched reply all cleared.
- States and db_estado codes:
  - INICIAL 0: go to ESPERA_BYTE when habilita = 1.
  - ESPERA_BYTE 1:
    - rx_pronto = 1: latch rx_dado, go to ACUMULA.
    - Otherwise, habilita = 0: discard partial frame, go to INICIAL.
    - Otherwise, mid-frame (at least one byte received) and timeout counter reaches TIMEOUT-1: go to ERRO.
  - ACUMULA 2: process the latched byte.
    - Digit position < N_DIGITOS and byte in 0x30..0x39: acc <= acc*10 + (byte - 0x30), truncated to LARGURA. Go to ESPERA_BYTE.
    - Digit position < N_DIGITOS and byte not a digit: go to ERRO.
    - Digit position = N_DIGITOS and byte != TERMINADOR: go to ERRO.
    - Digit position = N_DIGITOS and byte = TERMINADOR: store acc in shadow slot [sensor], clear acc and digit position, increment sensor. If this was the last sensor, copy all shadow slots to distancias and latch resposta, then go to VALIDA. Otherwise go to ESPERA_BYTE.
  - VALIDA 3: distancias_validas = 1; clear reply index; go to ENVIA.
  - ENVIA 4: tx_partida = 1; tx_dado = reply byte [index], MSB byte first. Go to ESPERA_TX.
  - ESPERA_TX 5: wait for tx_pronto, then go to PROX_ENVIO.
  - PROX_ENVIO 6: if index = N_RESPOSTA-1 go to FINAL, else increment index and go to ENVIA.
  - FINAL 7: pronto = 1; clear frame counters; go to ESPERA_BYTE if habilita = 1, else INICIAL.
  - ERRO 8: erro = 1; clear acc, digit, sensor and timeout counters; distancias keeps its previous values; go to ESPERA_BYTE.
  - Any other code: db_estado = 4'hF, next state INICIAL.
- Timing and counters:
  - Latency: terminator of the last field with rx_pronto in cycle t gives distancias_validas in cycle t+2, with new distancias already visible in that cycle. First tx_partida comes in cycle t+3.
  - tx_dado holds its value from ENVIA until the next ENVIA.
  - Timeout counter clears on every rx_pronto and outside ESPERA_BYTE. It increments only in ESPERA_BYTE while mid-frame.
- Boundary cases:
  - rx_pronto and timeout expiry in the same cycle: the byte is accepted.
  - rx_pronto in any state other than ESPERA_BYTE is ignored and the byte is dropped.
  - habilita = 0 during ACUMULA or any transmit state: the current frame/reply completes; habilita is checked only in INICIAL, ESPERA_BYTE and FINAL.
  - tx_pronto outside ESPERA_TX is ignored.
  - distancias never shows partially updated frames.

Decomposition:
- Shared package holds:
  - State encodings (4-bit).
  - ASCII constants: 0x30, 0x39, TERMINADOR default.
  - Default LARGURA.
- One sub-module is natural: roberto_ascii_acumulador. It contains the digit-validity check and the acc*10 + digit datapath, with clear and enable inputs and an invalid-digit flag output.
- FSM, counters and shadow registers stay in the top module.

Test Plan:
- Frame "123#045#999#", resposta = 24'h414243, tx_pronto returned 5 cycles after each tx_partida -> distancias_validas pulse once, distancias = {999, 45, 123}, tx_dado sequence 0x41, 0x42, 0x43, then pronto pulse.
- "12A#" -> erro pulse 2 cycles after the 'A' rx_pronto, distancias unchanged (0 after reset); a following valid frame is decoded correctly.
- TIMEOUT = 100: send "12", then idle -> erro after 100 idle cycles; with no bytes ever received, no erro is ever raised.
- Byte '7' pulsed during ESPERA_TX -> ignored; the next frame decodes exactly as sent.
- habilita dropped after "45" -> INICIAL (db_estado 0); re-enable, send a full frame -> values contain no stale digits.
- reset = 0 during ENVIA -> all outputs 0 immediately, db_estado 0, no further tx_partida.

Source files
------------

// File: rtl/roberto_resposta_uc_pkg.sv
// rtl/roberto_resposta_uc_pkg.sv - shared states, ASCII constants and defaults for roberto_resposta_uc
package roberto_resposta_uc_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    ESPERA_BYTE = 4'd1,
    ACUMULA     = 4'd2,
    VALIDA      = 4'd3,
    ENVIA       = 4'd4,
    ESPERA_TX   = 4'd5,
    PROX_ENVIO  = 4'd6,
    FINAL       = 4'd7,
    ERRO        = 4'd8
  } estado_t;

  localparam logic [7:0] ASCII_ZERO        = 8'h30;
  localparam logic [7:0] ASCII_NOVE        = 8'h39;
  localparam logic [7:0] TERMINADOR_PADRAO = 8'h23;
  localparam int         LARGURA_PADRAO    = 10;
  localparam logic [3:0] DB_INVALIDO       = 4'hF;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
  endfunction

endpackage

// File: rtl/roberto_ascii_acumulador.sv
// rtl/roberto_ascii_acumulador.sv - ASCII digit check and acc*10 + digit accumulator
module roberto_ascii_acumulador
  import roberto_resposta_uc_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               limpa_i,
  input  logic               habilita_i,
  input  logic [7:0]         dado_i,
  output logic [LARGURA-1:0] acc_o,
  output logic               digito_invalido_o
);

  logic [LARGURA-1:0] acc_q;
  logic [LARGURA-1:0] acc_d;
  logic [3:0]         digito;

  // For '0'..'9' the low nibble is already the digit value
  assign digito            = dado_i[3:0];
  assign digito_invalido_o = !eh_digito(dado_i);
  assign acc_o             = acc_q;

  // Next accumulator value: clear wins, otherwise shift in one decimal digit (wraps at LARGURA bits)
  always_comb begin
    acc_d = acc_q;
    if (limpa_i) begin
      acc_d = '0;
    end else if (habilita_i) begin
      acc_d = acc_q * LARGURA'(10) + LARGURA'(digito);
    end
  end

  // Accumulator register
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/roberto_resposta_uc.sv
// rtl/roberto_resposta_uc.sv - sensor frame decoder and servo reply transmitter control unit
module roberto_resposta_uc
  import roberto_resposta_uc_pkg::*;
#(
  parameter int         N_SENSORES = 3,
  parameter int         N_DIGITOS  = 3,
  parameter int         LARGURA    = LARGURA_PADRAO,
  parameter logic [7:0] TERMINADOR = TERMINADOR_PADRAO,
  parameter int         N_RESPOSTA = 3,
  parameter int         TIMEOUT    = 50_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          habilita,
  input  logic [7:0]                    rx_dado,
  input  logic                          rx_pronto,
  input  logic                          tx_pronto,
  input  logic [8*N_RESPOSTA-1:0]       resposta,
  output logic                          tx_partida,
  output logic [7:0]                    tx_dado,
  output logic [LARGURA*N_SENSORES-1:0] distancias,
  output logic                          distancias_validas,
  output logic                          erro,
  output logic                          pronto,
  output logic [3:0]                    db_estado
);

  localparam int DW = $clog2(N_DIGITOS + 1);
  localparam int SW = $clog2(N_SENSORES + 1);
  localparam int RW = $clog2(N_RESPOSTA + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DIG_MAX = DW'(N_DIGITOS);
  localparam logic [SW-1:0] SEN_ULT = SW'(N_SENSORES - 1);
  localparam logic [RW-1:0] IDX_ULT = RW'(N_RESPOSTA - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  estado_t                       estado_q;
  logic [7:0]                    byte_q;
  logic [DW-1:0]                 digito_q;
  logic [SW-1:0]                 sensor_q;
  logic [RW-1:0]                 idx_q;
  logic [TW-1:0]                 tempo_q;
  logic                          meio_q;
  logic [LARGURA*N_SENSORES-1:0] sombra_q;
  logic [LARGURA*N_SENSORES-1:0] sombra_d;
  logic [LARGURA*N_SENSORES-1:0] distancias_q;
  logic [8*N_RESPOSTA-1:0]       resposta_q;
  logic                          tx_partida_q;
  logic [7:0]                    tx_dado_q;
  logic                          validas_q;
  logic                          erro_q;
  logic                          pronto_q;

  logic                          acc_limpa;
  logic                          acc_en;
  logic                          terminador_ok;
  logic [LARGURA-1:0]            acc;
  logic                          digito_invalido;

  roberto_ascii_acumulador #(
    .LARGURA (LARGURA)
  ) u_acumulador (
    .clock_i           (clock),
    .reset_ni          (reset),
    .limpa_i           (acc_limpa),
    .habilita_i        (acc_en),
    .dado_i            (byte_q),
    .acc_o             (acc),
    .digito_invalido_o (digito_invalido)
  );

  // Accumulator control: digits only while the field still has room, cleared whenever a field ends or is dropped
  always_comb begin
    terminador_ok = (estado_q == ACUMULA) && (digito_q == DIG_MAX) && (byte_q == TERMINADOR);
    acc_en        = (estado_q == ACUMULA) && (digito_q < DIG_MAX) && !digito_invalido;
    acc_limpa     = terminador_ok || (estado_q == INICIAL) || (estado_q == ERRO) || (estado_q == FINAL);
  end

  // Shadow slots with the finished field merged in, so the last field can be published in the same edge
  always_comb begin
    sombra_d = sombra_q;
    for (int i = 0; i < N_SENSORES; i++) begin
      if (sensor_q == SW'(i)) begin
        sombra_d[i*LARGURA +: LARGURA] = acc;
      end
    end
  end

  // Control FSM with counters and registered pulse outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= INICIAL;
      byte_q       <= '0;
      digito_q     <= '0;
      sensor_q     <= '0;
      idx_q        <= '0;
      tempo_q      <= '0;
      meio_q       <= 1'b0;
      sombra_q     <= '0;
      distancias_q <= '0;
      resposta_q   <= '0;
      tx_partida_q <= 1'b0;
      tx_dado_q    <= '0;
      validas_q    <= 1'b0;
      erro_q       <= 1'b0;
      pronto_q     <= 1'b0;
    end else begin
      tx_partida_q <= 1'b0;
      validas_q    <= 1'b0;
      erro_q       <= 1'b0;
      pronto_q     <= 1'b0;
      tempo_q      <= '0;
      case (estado_q)
        INICIAL: begin
          digito_q <= '0;
          sensor_q <= '0;
          meio_q   <= 1'b0;
          if (habilita) estado_q <= ESPERA_BYTE;
        end
        ESPERA_BYTE: begin
          if (rx_pronto) begin
            byte_q   <= rx_dado;
            meio_q   <= 1'b1;
            estado_q <= ACUMULA;
          end else if (!habilita) begin
            estado_q <= INICIAL;
          end else if (meio_q) begin
            if (tempo_q == TMO_MAX) begin
              estado_q <= ERRO;
              erro_q   <= 1'b1;
            end else begin
              tempo_q <= tempo_q + TW'(1);
            end
          end
        end
        ACUMULA: begin
          if (digito_q < DIG_MAX) begin
            if (digito_invalido) begin
              estado_q <= ERRO;
              erro_q   <= 1'b1;
            end else begin
              digito_q <= digito_q + DW'(1);
              estado_q <= ESPERA_BYTE;
            end
          end else if (!terminador_ok) begin
            estado_q <= ERRO;
            erro_q   <= 1'b1;
          end else begin
            sombra_q <= sombra_d;
            digito_q <= '0;
            if (sensor_q == SEN_ULT) begin
              sensor_q     <= '0;
              distancias_q <= sombra_d;
              resposta_q   <= resposta;
              validas_q    <= 1'b1;
              estado_q     <= VALIDA;
            end else begin
              sensor_q <= sensor_q + SW'(1);
              estado_q <= ESPERA_BYTE;
            end
          end
        end
        VALIDA: begin
          // Reply goes out MSB byte first: take the top byte and shift the rest up
          idx_q        <= '0;
          tx_partida_q <= 1'b1;
          tx_dado_q    <= resposta_q[8*N_RESPOSTA-1 -: 8];
          resposta_q   <= resposta_q << 8;
          estado_q     <= ENVIA;
        end
        ENVIA: begin
          estado_q <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (tx_pronto) estado_q <= PROX_ENVIO;
        end
        PROX_ENVIO: begin
          if (idx_q == IDX_ULT) begin
            pronto_q <= 1'b1;
            estado_q <= FINAL;
          end else begin
            idx_q        <= idx_q + RW'(1);
            tx_partida_q <= 1'b1;
            tx_dado_q    <= resposta_q[8*N_RESPOSTA-1 -: 8];
            resposta_q   <= resposta_q << 8;
            estado_q     <= ENVIA;
          end
        end
        FINAL: begin
          digito_q <= '0;
          sensor_q <= '0;
          meio_q   <= 1'b0;
          estado_q <= habilita ? ESPERA_BYTE : INICIAL;
        end
        ERRO: begin
          digito_q <= '0;
          sensor_q <= '0;
          meio_q   <= 1'b0;
          estado_q <= ESPERA_BYTE;
        end
        default: begin
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  // Debug state code; anything outside the known encodings reads as F
  always_comb begin
    case (estado_q)
      INICIAL:     db_estado = 4'd0;
      ESPERA_BYTE: db_estado = 4'd1;
      ACUMULA:     db_estado = 4'd2;
      VALIDA:      db_estado = 4'd3;
      ENVIA:       db_estado = 4'd4;
      ESPERA_TX:   db_estado = 4'd5;
      PROX_ENVIO:  db_estado = 4'd6;
      FINAL:       db_estado = 4'd7;
      ERRO:        db_estado = 4'd8;
      default:     db_estado = DB_INVALIDO;
    endcase
  end

  assign tx_partida         = tx_partida_q;
  assign tx_dado            = tx_dado_q;
  assign distancias         = distancias_q;
  assign distancias_validas = validas_q;
  assign erro               = erro_q;
  assign pronto             = pronto_q;

endmodule
